// File: rtl/fft_pkg.sv
// Shared FFT definitions.
//   N_POINTS / LOG2_N : transform size and bin-index width
//   fft_state_e       : serializer state encoding (IDLE, STREAM)
//   ST_IDLE/ST_STREAM : plain-vector aliases of the state encoding
//   bitrev5()         : 5-bit index bit reversal (Stage5 order -> bin order)
package fft_pkg;

  localparam int N_POINTS = 32;
  localparam int LOG2_N   = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fft_state_e;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  function automatic logic [LOG2_N-1:0] bitrev5(input logic [LOG2_N-1:0] idx);
    logic [LOG2_N-1:0] r;
    for (int b = 0; b < LOG2_N; b++) r[b] = idx[LOG2_N-1-b];
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// 32-entry complex frame store.
//   clk          : rising-edge clock
//   we           : load all 32 entries at once from the two buses
//   wr_real_bus  : entry k real at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_imag_bus  : entry k imaginary, same packing
//   rd_addr      : combinational read index
//   rd_real/imag : entry at rd_addr
// No reset: contents are only observed after a load.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [N_POINTS*DATA_WIDTH-1:0] wr_real_bus,
  input  logic [N_POINTS*DATA_WIDTH-1:0] wr_imag_bus,
  input  logic [LOG2_N-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_real,
  output logic [DATA_WIDTH-1:0]          rd_imag
);

  // Packed layout matches the bus packing, so a whole-frame load is a
  // plain vector copy.
  logic [N_POINTS-1:0][DATA_WIDTH-1:0] mem_re;
  logic [N_POINTS-1:0][DATA_WIDTH-1:0] mem_im;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_re <= wr_real_bus;
      mem_im <= wr_imag_bus;
    end
  end

  assign rd_real = mem_re[rd_addr];
  assign rd_imag = mem_im[rd_addr];

endmodule

// File: rtl/fft_output_serializer.sv
// Captures a parallel 32-point Stage5 result and streams it one bin per
// valid/ready handshake.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   stage5_finish     : one-cycle pulse, Stage5 buses valid this cycle
//   stage5_real_bus   : out k real at [k*DATA_WIDTH +: DATA_WIDTH]
//   stage5_imag_bus   : out k imaginary, same packing
//   out_valid/ready   : stream handshake
//   out_real/imag     : streamed sample (zero while idle)
//   out_index         : bin number, out_last marks bin 31
//   busy              : a frame is held / streaming
//   overflow          : one-cycle pulse, an incoming frame was dropped
// Build option: define FFT_OUT_BITREV_EN to read the buffer at bitrev5(cnt)
// (natural-order bins from bit-reversed Stage5 outputs); otherwise the
// buffer is read straight at cnt.
// INTEGER/FRACTION describe the fixed-point format only; data passes
// through untouched.
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INTEGER    = 4,
  parameter int FRACTION   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stage5_finish,
  input  logic [32*DATA_WIDTH-1:0] stage5_real_bus,
  input  logic [32*DATA_WIDTH-1:0] stage5_imag_bus,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_real,
  output logic [DATA_WIDTH-1:0]   out_imag,
  output logic [4:0]              out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overflow
);

  localparam logic [LOG2_N-1:0] LAST_BIN = LOG2_N'(N_POINTS - 1);

  // Format metadata sanity hook; no hardware depends on it.
  if (INTEGER + FRACTION > DATA_WIDTH) begin : g_fmt_wider_than_word
  end

  logic [0:0]            state;
  logic [LOG2_N-1:0]     cnt;
  logic [LOG2_N-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_real;
  logic [DATA_WIDTH-1:0] rd_imag;
  logic                  hs;
  logic                  hs_last;
  logic                  capture;

  assign hs      = out_valid & out_ready;
  assign hs_last = hs & (cnt == LAST_BIN);
  // A new frame is accepted when idle, or exactly as the final bin leaves
  // (back-to-back frames without a bubble). Reset wins over a same-cycle pulse.
  assign capture = stage5_finish & ~reset & ((state == ST_IDLE) | hs_last);

`ifdef FFT_OUT_BITREV_EN
  assign rd_addr = bitrev5(cnt);
`else
  assign rd_addr = cnt;
`endif

  fft_frame_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .we          (capture),
    .wr_real_bus (stage5_real_bus),
    .wr_imag_bus (stage5_imag_bus),
    .rd_addr     (rd_addr),
    .rd_real     (rd_real),
    .rd_imag     (rd_imag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (stage5_finish) begin
            state <= ST_STREAM;
            cnt   <= '0;
          end
        end
        default: begin
          if (hs) begin
            if (cnt == LAST_BIN) begin
              cnt   <= '0;
              state <= stage5_finish ? ST_STREAM : ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          // Any pulse that is not the seamless hand-over drops the new frame.
          if (stage5_finish && !hs_last) overflow <= 1'b1;
        end
      endcase
    end
  end

  // Buffer contents are undefined until the first capture, so data is
  // gated to zero outside STREAM.
  assign out_valid = (state == ST_STREAM);
  assign busy      = out_valid;
  assign out_index = cnt;
  assign out_last  = out_valid & (cnt == LAST_BIN);
  assign out_real  = out_valid ? rd_real : '0;
  assign out_imag  = out_valid ? rd_imag : '0;

endmodule

// File: tb/tb_fft_output_serializer.sv
module tb_fft_output_serializer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          stage5_finish;
  logic [32*DW-1:0] rbus, ibus;
  logic          out_valid, out_ready, out_last, busy, overflow;
  logic [DW-1:0] out_real, out_imag;
  logic [4:0]    out_index;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_output_serializer #(.DATA_WIDTH(DW), .INTEGER(4), .FRACTION(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .stage5_finish   (stage5_finish),
    .stage5_real_bus (rbus),
    .stage5_imag_bus (ibus),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_real        (out_real),
    .out_imag        (out_imag),
    .out_index       (out_index),
    .out_last        (out_last),
    .busy            (busy),
    .overflow        (overflow)
  );

  typedef struct {
    logic [4:0]    idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } vec_t;

  vec_t tbl[32];

  // Buffer entry expected to be streamed for a given bin counter.
  function automatic int src(input int i);
`ifdef FFT_OUT_BITREV_EN
    int r = 0;
    for (int b = 0; b < 5; b++) if (((i >> b) & 1) != 0) r |= 1 << (4 - b);
    return r;
`else
    return i;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: ramp (real=k, imag=-k); kind 1: real=100+k, imag=k
  task automatic load_bus(input int kind);
    for (int k = 0; k < 32; k++) begin
      rbus[k*DW +: DW] = (kind == 0) ? DW'(k) : DW'(100 + k);
      ibus[k*DW +: DW] = (kind == 0) ? DW'(256 - k) : DW'(k);
    end
  endtask

  task automatic start_frame(input int kind);
    load_bus(kind);
    stage5_finish = 1'b1;
    tick();
    stage5_finish = 1'b0;
  endtask

  task automatic advance(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (busy && guard < 64) begin
      tick();
      guard++;
    end
    chk("drain_busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl[i].idx  = 5'(i);
      tbl[i].re   = DW'(src(i));
      tbl[i].im   = DW'(256 - src(i));
      tbl[i].last = (i == 31);
    end

    reset = 1'b1; stage5_finish = 1'b0; out_ready = 1'b0;
    load_bus(0);
    tick(); tick();
    // finish coincident with reset must be ignored
    stage5_finish = 1'b1;
    tick();
    stage5_finish = 1'b0;
    reset = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_index", {27'd0, out_index}, 32'd0);
    chk("rst_real", {24'd0, out_real}, 32'd0);
    chk("rst_imag", {24'd0, out_imag}, 32'd0);
    tick();
    chk("rst_finish_ignored", {31'd0, busy}, 32'd0);

    // full frame, ready always high
    start_frame(0);
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("ramp_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("ramp_busy[%0d]", i), {31'd0, busy}, 32'd1);
      chk($sformatf("ramp_index[%0d]", i), {27'd0, out_index}, {27'd0, tbl[i].idx});
      chk($sformatf("ramp_real[%0d]", i), {24'd0, out_real}, {24'd0, tbl[i].re});
      chk($sformatf("ramp_imag[%0d]", i), {24'd0, out_imag}, {24'd0, tbl[i].im});
      chk($sformatf("ramp_last[%0d]", i), {31'd0, out_last}, {31'd0, tbl[i].last});
      tick();
    end
    chk("ramp_end_valid", {31'd0, out_valid}, 32'd0);
    chk("ramp_end_busy", {31'd0, busy}, 32'd0);

    // backpressure at cnt=5: ready 0,0 then 1
    start_frame(0);
    advance(5);
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("stall_index[%0d]", s), {27'd0, out_index}, 32'd5);
      chk($sformatf("stall_real[%0d]", s), {24'd0, out_real}, 32'(src(5)));
      tick();
    end
    chk("stall_hold_index", {27'd0, out_index}, 32'd5);
    out_ready = 1'b1;
    tick();
    chk("stall_resume_index", {27'd0, out_index}, 32'd6);
    chk("stall_resume_real", {24'd0, out_real}, 32'(src(6)));
    drain();

    // frame dropped mid-stream at cnt=10
    start_frame(0);
    advance(10);
    chk("ovf_pre", {31'd0, overflow}, 32'd0);
    load_bus(1);
    stage5_finish = 1'b1;
    tick();
    stage5_finish = 1'b0;
    chk("ovf_pulse", {31'd0, overflow}, 32'd1);
    chk("ovf_index", {27'd0, out_index}, 32'd11);
    chk("ovf_real_orig", {24'd0, out_real}, 32'(src(11)));
    tick();
    chk("ovf_single", {31'd0, overflow}, 32'd0);
    advance(31 - 12);
    chk("ovf_last_index", {27'd0, out_index}, 32'd31);
    chk("ovf_last_real_orig", {24'd0, out_real}, 32'(src(31)));
    chk("ovf_last_flag", {31'd0, out_last}, 32'd1);
    drain();

    // seamless hand-over on the final handshake
    start_frame(0);
    advance(31);
    chk("b2b_at31", {27'd0, out_index}, 32'd31);
    load_bus(1);
    stage5_finish = 1'b1;
    tick();
    stage5_finish = 1'b0;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_index", {27'd0, out_index}, 32'd0);
    chk("b2b_real", {24'd0, out_real}, 32'(100 + src(0)));
    chk("b2b_imag", {24'd0, out_imag}, 32'(src(0)));
    chk("b2b_no_ovf", {31'd0, overflow}, 32'd0);
    tick();
    chk("b2b_index1", {27'd0, out_index}, 32'd1);
    chk("b2b_real1", {24'd0, out_real}, 32'(100 + src(1)));
    chk("b2b_no_ovf2", {31'd0, overflow}, 32'd0);
    drain();

    // reset mid-frame at cnt=20
    start_frame(0);
    advance(20);
    chk("rstmid_at20", {27'd0, out_index}, 32'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_real", {24'd0, out_real}, 32'd0);
    chk("rstmid_index", {27'd0, out_index}, 32'd0);
    start_frame(1);
    chk("rstmid_new_valid", {31'd0, out_valid}, 32'd1);
    chk("rstmid_new_index", {27'd0, out_index}, 32'd0);
    chk("rstmid_new_real", {24'd0, out_real}, 32'(100 + src(0)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
